cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares the single multi-cycle main memory between the I-cache fill FSM, the D-cache fill FSM
//  and D-cache write-through stores. Grants one requester at a time and muxes its address/control
//  onto the memory port. Holds a fill grant until all block beats have returned, then routes
//  mem_data_valid only to the granted cache.
// PARAMETERS
//  ADDR_W   16  address width (bytes)
//  DATA_W   16  memory word width
//  BEATS    8   words per cache block; fill ends on BEATS-th data_valid
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       synchronous, active-low reset
//  i_req         in   1       I-cache fill request (level, held until i_grant)
//  i_addr        in   ADDR_W  I-cache fill address (advanced by the fill FSM each beat)
//  i_grant       out  1       I-cache owns memory
//  i_data_valid  out  1       mem_data_valid routed to I-cache
//  d_req         in   1       D-cache request (fill or store)
//  d_wr          in   1       qualifies d_req: 1 = write-through store, 0 = fill
//  d_addr        in   ADDR_W  D-cache address
//  d_wdata       in   DATA_W  store data
//  d_grant       out  1       D-cache owns memory
//  d_data_valid  out  1       mem_data_valid routed to D-cache
//  d_wr_done     out  1       one-cycle pulse: store issued
//  mem_addr      out  ADDR_W  memory address (granted requester's)
//  mem_enable    out  1       memory access strobe
//  mem_wr        out  1       memory write enable
//  mem_wdata     out  DATA_W  memory write data
//  mem_data_valid in  1       read beat returned by memory
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE, counters 0, rr pointer = I; all outputs 0 (mem_addr/mem_wdata 0).
//  - States: IDLE, FILL_I, FILL_D, WRITE_D (registered). Grants decoded from state, no comb path req->grant.
//  - Arbitration runs in IDLE and in the completion cycle of a fill/write (back-to-back, no bubble).
//    Request seen at posedge N -> grant high from cycle N+1.
//  - Priority: d_req over i_req (fixed); d_req&d_wr -> WRITE_D, d_req&~d_wr -> FILL_D.
//  - FILL_x: mem_addr = x_addr; mem_enable = 1 while issued < BEATS (issue counter counts enables);
//    mem_wr=0. Beat counter counts mem_data_valid; x_data_valid = mem_data_valid.
//    Completion: mem_data_valid with beat==BEATS-1 -> counters clear, re-arbitrate.
//  - WRITE_D: exactly one cycle; mem_enable=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata,
//    d_grant=1, d_wr_done=1; then re-arbitrate.
//  - Requester dropping req mid-fill: ignored; fill runs to BEATS beats (memory in flight).
//  - mem_data_valid in IDLE/WRITE_D: discarded, neither *_data_valid asserted, counters unchanged.
//  - Counters ceil(log2(BEATS))+1 bits, wrap impossible: saturate at BEATS for issue count.
//  - Reset mid-fill: abandons transfer immediately; subsequent stray data_valid discarded.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: when i_req and d_req both pending at arbitration, grant the one not
//  served last (1-bit rr pointer, updated on each grant). Undefined: fixed D-over-I priority,
//  no pointer flop.
// STRUCTURE
//  Package cache_arb_pkg: state encoding localparams (IDLE/FILL_I/FILL_D/WRITE_D), BEATS default,
//  CNT_W. Sub-module arb_beat_counter (clear, incr, count, last flag) instantiated twice
//  (issue and beat). Output mux + FSM in this module.
// TESTING
//  1 i_req=1,i_addr=0x0100 from IDLE -> i_grant cycle+1, 8 mem_enable cycles, 8 valids -> 8 i_data_valid, grant drops after 8th.
//  2 i_req and d_req(d_wr=0) same cycle -> d_grant first; RR build: I next; fixed build: D again if still requesting.
//  3 d_req,d_wr=1,d_addr=0x2000,d_wdata=0xBEEF during FILL_I -> waits; after 8th beat WRITE_D one cycle, mem_wr=1, d_wr_done pulse.
//  4 mem_data_valid pulsed in IDLE -> no *_data_valid, next fill still counts 8 beats.
//  5 rst_n=0 after 3rd beat of FILL_D -> all outputs 0 next cycle, state IDLE, new i_req served cleanly.
//  6 i_req dropped after grant -> fill continues to 8 beats; back-to-back d_req granted with no idle cycle.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types for the cache/memory arbiter: FSM state encoding, block size and
// counter width, plus the debug view exported by the top.
package cache_arb_pkg;

    localparam int BEATS_DEF = 8;

    function automatic int cnt_width(input int beats);
        return $clog2(beats) + 1;
    endfunction

    localparam int CNT_W = cnt_width(BEATS_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL_I  = 2'd1,
        FILL_D  = 2'd2,
        WRITE_D = 2'd3
    } arb_state_t;

    typedef struct packed {
        arb_state_t       state;
        logic [CNT_W-1:0] issued;
        logic [CNT_W-1:0] beats;
    } arb_dbg_t;

endpackage

// File: rtl/arb_beat_counter.sv
// Saturating up-counter with synchronous clear; counts 0..LIMIT-1 and holds there.
// 'last' flags the terminal value LIMIT-1.
module arb_beat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         incr,
    output logic [W-1:0] count,
    output logic         last
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (incr && !last) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == W'(LIMIT - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single main-memory port between I-cache fills, D-cache fills and
// D-cache write-through stores. Optional round-robin tie-break: ARB_ROUND_ROBIN_EN.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BEATS  = BEATS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_data_valid,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_data_valid,
    output logic              d_wr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_valid,
    output arb_dbg_t          dbg
);

    localparam int CW = cnt_width(BEATS);

    // Handshake: a requester holds x_req (and d_wr) until it sees its grant; the grant is
    // registered, so a request sampled at edge N owns memory from cycle N+1 onward.
    arb_state_t    state, state_nxt, pick;
    logic          is_fill, fill_done, rearb, serve_d;
    logic [CW-1:0] issue_cnt, beat_cnt;
    logic          issue_last, beat_last;

    assign is_fill   = (state == FILL_I) || (state == FILL_D);
    assign fill_done = is_fill && mem_data_valid && beat_last;
    assign rearb     = (state == IDLE) || (state == WRITE_D) || fill_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_d <= 1'b0;
        end else if (rearb && (pick != IDLE)) begin
            rr_last_d <= (pick != FILL_I);
        end
    end

    always_comb begin
        serve_d = d_req;
        if (d_req && i_req) serve_d = !rr_last_d;
    end
`else
    assign serve_d = d_req;
`endif

    always_comb begin
        if (serve_d)    pick = d_wr ? WRITE_D : FILL_D;
        else if (i_req) pick = FILL_I;
        else            pick = IDLE;
    end

    // Issue counter saturates at BEATS so enables stop once the whole block is requested.
    arb_beat_counter #(.W(CW), .LIMIT(BEATS + 1)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (fill_done),
        .incr  (mem_enable && !mem_wr),
        .count (issue_cnt),
        .last  (issue_last)
    );

    arb_beat_counter #(.W(CW), .LIMIT(BEATS)) u_beat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (fill_done),
        .incr  (is_fill && mem_data_valid),
        .count (beat_cnt),
        .last  (beat_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        i_grant      = 1'b0;
        i_data_valid = 1'b0;
        d_grant      = 1'b0;
        d_data_valid = 1'b0;
        d_wr_done    = 1'b0;
        mem_addr     = '0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_wdata    = '0;
        case (state)
            IDLE: state_nxt = pick;
            FILL_I: begin
                i_grant      = 1'b1;
                mem_addr     = i_addr;
                mem_enable   = !issue_last;
                i_data_valid = mem_data_valid;
                if (fill_done) state_nxt = pick;
            end
            FILL_D: begin
                d_grant      = 1'b1;
                mem_addr     = d_addr;
                mem_enable   = !issue_last;
                d_data_valid = mem_data_valid;
                if (fill_done) state_nxt = pick;
            end
            WRITE_D: begin
                d_grant    = 1'b1;
                d_wr_done  = 1'b1;
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
                state_nxt  = pick;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dbg.state  = state;
    assign dbg.issued = CNT_W'(issue_cnt);
    assign dbg.beats  = CNT_W'(beat_cnt);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level owner/beat model. Define ARB_ROUND_ROBIN_EN to match the DUT build.
module tb_cache_mem_arbiter;
    import cache_arb_pkg::*;

    localparam int BEATS = 8;

    logic        clk = 1'b0;
    logic        rst_n, i_req, d_req, d_wr, mem_data_valid;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_grant, i_data_valid, d_grant, d_data_valid, d_wr_done;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    arb_dbg_t    dbg;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_data_valid(d_data_valid), .d_wr_done(d_wr_done),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_data_valid(mem_data_valid), .dbg(dbg)
    );

    // Reference: who owns memory (0 none, 1 I fill, 2 D fill, 3 D store) and beats issued/returned.
    int  own, issued, returned, fills_done, cyc;
    bit  last_d;
    int  n_own, n_iss, n_ret;
    bit  n_last_d;
    int  ret_q[$];
    int  last_ret;
    int  total, bad;
    int  obs_idv, obs_ddv, obs_done;
    bit  rand_mode, stray_en, hold_d;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic arb_state_t own_state(input int o);
        case (o)
            1:       return FILL_I;
            2:       return FILL_D;
            3:       return WRITE_D;
            default: return IDLE;
        endcase
    endfunction

    task automatic arbitrate();
        bit take_d = d_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && i_req) take_d = !last_d;
`endif
        n_iss = 0;
        n_ret = 0;
        if (take_d) begin
            n_own = d_wr ? 3 : 2;
            n_last_d = 1'b1;
        end else if (i_req) begin
            n_own = 1;
            n_last_d = 1'b0;
        end else begin
            n_own = 0;
        end
    endtask

    task automatic step();
        logic [15:0] e_addr, e_wd;
        logic e_ig, e_idv, e_dg, e_ddv, e_done, e_en, e_wr;
        int t;
        @(negedge clk);
        {e_ig, e_idv, e_dg, e_ddv, e_done, e_en, e_wr} = '0;
        e_addr = '0;
        e_wd   = '0;
        case (own)
            1: begin e_ig = 1; e_addr = i_addr; e_en = (issued < BEATS); e_idv = mem_data_valid; end
            2: begin e_dg = 1; e_addr = d_addr; e_en = (issued < BEATS); e_ddv = mem_data_valid; end
            3: begin e_dg = 1; e_done = 1; e_en = 1; e_wr = 1; e_addr = d_addr; e_wd = d_wdata; end
            default: ;
        endcase
        check_eq("i_grant", i_grant, e_ig);
        check_eq("i_data_valid", i_data_valid, e_idv);
        check_eq("d_grant", d_grant, e_dg);
        check_eq("d_data_valid", d_data_valid, e_ddv);
        check_eq("d_wr_done", d_wr_done, e_done);
        check_eq("mem_enable", mem_enable, e_en);
        check_eq("mem_wr", mem_wr, e_wr);
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_wdata", mem_wdata, e_wd);
        check_eq("state", dbg.state, own_state(own));
        check_eq("issued", dbg.issued, issued);
        check_eq("beats", dbg.beats, returned);
        if (i_data_valid === 1'b1) obs_idv++;
        if (d_data_valid === 1'b1) obs_ddv++;
        if (d_wr_done === 1'b1)    obs_done++;
        // memory returns each read beat in order after 1..4 cycles
        if (e_en && !e_wr) begin
            t = cyc + $urandom_range(1, 4);
            if (t <= last_ret) t = last_ret + 1;
            last_ret = t;
            ret_q.push_back(t);
        end
        // requesters release once they own memory
        if (e_ig) i_req = 1'b0;
        if (e_dg && !hold_d) d_req = 1'b0;
        if (!rst_n) begin
            n_own = 0; n_iss = 0; n_ret = 0; n_last_d = 1'b0;
        end else begin
            n_own = own; n_iss = issued; n_ret = returned; n_last_d = last_d;
            if (own == 0 || own == 3) begin
                arbitrate();
            end else if (mem_data_valid && returned == BEATS - 1) begin
                fills_done++;
                arbitrate();
            end else begin
                n_iss = (issued < BEATS) ? issued + 1 : issued;
                n_ret = returned + int'(mem_data_valid);
            end
        end
        @(posedge clk);
        #1;
        own = n_own; issued = n_iss; returned = n_ret; last_d = n_last_d;
        cyc++;
        mem_data_valid = 1'b0;
        if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
            void'(ret_q.pop_front());
            mem_data_valid = 1'b1;
        end else if (stray_en && ret_q.size() == 0 && (own == 0 || own == 3)
                     && $urandom_range(0, 7) == 0) begin
            mem_data_valid = 1'b1;
        end
        if (rand_mode) begin
            i_addr  = 16'($urandom);
            d_addr  = 16'($urandom);
            d_wdata = 16'($urandom);
            if (!i_req && $urandom_range(0, 3) == 0) i_req = 1'b1;
            if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1'b1;
                d_wr  = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic wait_fill_done(input string tag);
        int start = fills_done;
        int k = 0;
        while (fills_done == start && k < 200) begin
            step();
            k++;
        end
        check_eq(tag, fills_done != start, 1);
    endtask

    task automatic wait_beats(input string tag, input int o, input int r);
        int k = 0;
        while (!(own == o && returned == r) && k < 200) begin
            step();
            k++;
        end
        check_eq(tag, own == o && returned == r, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!(own == 0 && !i_req && !d_req && ret_q.size() == 0) && k < 400) begin
            step();
            k++;
        end
        check_eq(tag, own == 0 && !i_req && !d_req && ret_q.size() == 0, 1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; last_ret = 0; fills_done = 0;
        own = 0; issued = 0; returned = 0; last_d = 1'b0;
        rand_mode = 0; stray_en = 0; hold_d = 0;
        rst_n = 1'b0; i_req = 0; d_req = 0; d_wr = 0; mem_data_valid = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // single I-cache fill from idle
        i_addr = 16'h0100;
        obs_idv = 0;
        i_req = 1'b1;
        wait_fill_done("t1_fill");
        check_eq("t1_grant_drop", i_grant, 0);
        wait_idle("t1_idle");
        check_eq("t1_beats", obs_idv, BEATS);

        // simultaneous I and D fill requests; D keeps requesting
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400; hold_d = 1;
        step();
        check_eq("t2_d_first", d_grant, 1);
        wait_fill_done("t2_fill");
`ifdef ARB_ROUND_ROBIN_EN
        check_eq("t2_second", dbg.state, FILL_I);
`else
        check_eq("t2_second", dbg.state, FILL_D);
`endif
        hold_d = 0;
        wait_idle("t2_idle");

        // store waits behind an I fill, then issues for exactly one cycle
        i_addr = 16'h0200;
        i_req = 1'b1;
        step();
        step();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h2000; d_wdata = 16'hBEEF;
        obs_done = 0;
        wait_fill_done("t3_fill");
        check_eq("t3_write_state", dbg.state, WRITE_D);
        check_eq("t3_mem_wdata", mem_wdata, 16'hBEEF);
        wait_idle("t3_idle");
        check_eq("t3_done_pulses", obs_done, 1);

        // stray data_valid while idle is discarded
        mem_data_valid = 1'b1;
        step();
        obs_idv = 0;
        i_req = 1'b1;
        wait_idle("t4_idle");
        check_eq("t4_beats", obs_idv, BEATS);

        // reset in the middle of a D fill
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h3000;
        wait_beats("t5_three_beats", 2, 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("t5_state", dbg.state, IDLE);
        check_eq("t5_d_grant", d_grant, 0);
        wait_idle("t5_drain");
        obs_idv = 0;
        i_req = 1'b1;
        wait_idle("t5_refill");
        check_eq("t5_beats", obs_idv, BEATS);

        // requester drops after grant; D fill follows with no idle cycle
        i_req = 1'b1;
        step();
        step();
        d_req = 1'b1; d_wr = 1'b0;
        wait_fill_done("t6_fill");
        check_eq("t6_b2b", dbg.state, FILL_D);
        wait_idle("t6_idle");

        // random traffic
        rand_mode = 1; stray_en = 1;
        repeat (3000) step();
        rand_mode = 0; stray_en = 0;
        wait_idle("rand_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
